// File: rtl/uram_2w2r_arbiter.sv
// Round-robin arbiter sharing both ports of a 2W/2R URAM among NUM_REQ requesters,
// with a zero-fill clear sequencer that drives both ports while requesters are locked out.
module uram_2w2r_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned ADDR_RANGE = 4096
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data,
    input  logic                          clr_start,
    output logic                          clr_busy,
    output logic                          clr_done,
    output logic                          ce0,
    output logic                          we0,
    output logic [ADDR_WIDTH-1:0]         addr0,
    output logic [DATA_WIDTH-1:0]         wdata0,
    input  logic [DATA_WIDTH-1:0]         rdata0,
    output logic                          ce1,
    output logic                          we1,
    output logic [ADDR_WIDTH-1:0]         addr1,
    output logic [DATA_WIDTH-1:0]         wdata1,
    input  logic [DATA_WIDTH-1:0]         rdata1
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_WIDTH-1:0] ClrLast = ADDR_WIDTH'(ADDR_RANGE / 2 - 1);

    typedef enum logic [0:0] {StServe, StClear} state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  clr_done_q, clr_done_d;
    logic                  rsp0_vld_q, rsp0_vld_d, rsp1_vld_q, rsp1_vld_d;
    logic [IdxW-1:0]       rsp0_id_q, rsp0_id_d, rsp1_id_q, rsp1_id_d;

    logic                  serve_en;
    logic                  g0_vld, g1_vld, g1_cand;
    logic [IdxW-1:0]       g0_idx, g1_idx;
    logic [ADDR_WIDTH-1:0] g0_addr, g1_addr;
    logic [DATA_WIDTH-1:0] g0_wdata, g1_wdata;
    logic                  g0_we, g1_we;

    assign serve_en = rst_n && (state_q == StServe);

    // Cyclic scan from rr_ptr; first two valid requesters become port-0 / port-1 candidates.
    always_comb begin
        g0_vld  = 1'b0;
        g1_cand = 1'b0;
        g0_idx  = '0;
        g1_idx  = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            automatic logic [IdxW-1:0] cand;
            cand = IdxW'((32'(rr_ptr_q) + j) % NUM_REQ);
            if (serve_en && req_valid[cand]) begin
                if (!g0_vld) begin
                    g0_vld = 1'b1;
                    g0_idx = cand;
                end else if (!g1_cand) begin
                    g1_cand = 1'b1;
                    g1_idx  = cand;
                end
            end
        end
    end

    assign g0_addr  = req_addr[32'(g0_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign g1_addr  = req_addr[32'(g1_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign g0_wdata = req_wdata[32'(g0_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign g1_wdata = req_wdata[32'(g1_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign g0_we    = req_we[g0_idx];
    assign g1_we    = req_we[g1_idx];

    // Two writes to one address in the same cycle: the port-1 requester retries.
    assign g1_vld = g1_cand && !(g0_we && g1_we && (g0_addr == g1_addr));

    always_comb begin
        req_ready = '0;
        ce0       = 1'b0;
        we0       = 1'b0;
        addr0     = '0;
        wdata0    = '0;
        ce1       = 1'b0;
        we1       = 1'b0;
        addr1     = '0;
        wdata1    = '0;
        if (rst_n && state_q == StClear) begin
            ce0   = 1'b1;
            we0   = 1'b1;
            addr0 = {clr_cnt_q[ADDR_WIDTH-2:0], 1'b0};
            ce1   = 1'b1;
            we1   = 1'b1;
            addr1 = {clr_cnt_q[ADDR_WIDTH-2:0], 1'b1};
        end else begin
            if (g0_vld) begin
                req_ready[g0_idx] = 1'b1;
                ce0               = 1'b1;
                we0               = g0_we;
                addr0             = g0_addr;
                wdata0            = g0_wdata;
            end
            if (g1_vld) begin
                req_ready[g1_idx] = 1'b1;
                ce1               = 1'b1;
                we1               = g1_we;
                addr1             = g1_addr;
                wdata1            = g1_wdata;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        clr_cnt_d  = clr_cnt_q;
        clr_done_d = 1'b0;
        rsp0_vld_d = 1'b0;
        rsp1_vld_d = 1'b0;
        rsp0_id_d  = g0_idx;
        rsp1_id_d  = g1_idx;
        unique case (state_q)
            StServe: begin
                rsp0_vld_d = g0_vld && !g0_we;
                rsp1_vld_d = g1_vld && !g1_we;
                if (g1_vld) begin
                    rr_ptr_d = (32'(g1_idx) == NUM_REQ - 1) ? '0 : g1_idx + 1'b1;
                end else if (g0_vld) begin
                    rr_ptr_d = (32'(g0_idx) == NUM_REQ - 1) ? '0 : g0_idx + 1'b1;
                end
                if (clr_start) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                if (clr_cnt_q == ClrLast) begin
                    state_d    = StServe;
                    clr_cnt_d  = '0;
                    clr_done_d = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: state_d = StServe;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StServe;
            rr_ptr_q   <= '0;
            clr_cnt_q  <= '0;
            clr_done_q <= 1'b0;
            rsp0_vld_q <= 1'b0;
            rsp1_vld_q <= 1'b0;
            rsp0_id_q  <= '0;
            rsp1_id_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            clr_cnt_q  <= clr_cnt_d;
            clr_done_q <= clr_done_d;
            rsp0_vld_q <= rsp0_vld_d;
            rsp1_vld_q <= rsp1_vld_d;
            rsp0_id_q  <= rsp0_id_d;
            rsp1_id_q  <= rsp1_id_d;
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (rsp0_vld_q) begin
            rsp_valid[rsp0_id_q]                            = 1'b1;
            rsp_data[32'(rsp0_id_q)*DATA_WIDTH +: DATA_WIDTH] = rdata0;
        end
        if (rsp1_vld_q) begin
            rsp_valid[rsp1_id_q]                            = 1'b1;
            rsp_data[32'(rsp1_id_q)*DATA_WIDTH +: DATA_WIDTH] = rdata1;
        end
    end

    assign clr_busy = (state_q == StClear);
    assign clr_done = clr_done_q;

endmodule

// File: tb/tb_uram_2w2r_arbiter.sv
// Bench for uram_2w2r_arbiter: URAM behavioural model plus a transaction-level reference
// (rotated candidate list, shadow memory, expected-response table) checked every cycle.
module tb_uram_2w2r_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 12;
    localparam int unsigned AR = 4096;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid, req_ready, req_we, rsp_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata, rsp_data;
    logic              clr_start, clr_busy, clr_done;
    logic              ce0, we0, ce1, we1;
    logic [AW-1:0]     addr0, addr1;
    logic [DW-1:0]     wdata0, wdata1, rdata0, rdata1;

    uram_2w2r_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ADDR_RANGE(AR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .ce0(ce0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0),
        .ce1(ce1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .rdata1(rdata1)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(int unsigned a);
        return (a == 32'h010) ? 64'hA5 : {32'hC0DE_0000, a};
    endfunction

    // URAM model: 1-cycle read latency, a write on either port is visible to a same-cycle read.
    logic [DW-1:0] mem [AR];
    bit            written [AR];

    function automatic logic [DW-1:0] mem_rd(logic [AW-1:0] a);
        return written[a] ? mem[a] : init_val(32'(a));
    endfunction

    always @(posedge clk) begin
        if (ce0) begin
            rdata0 <= (ce1 && we1 && addr1 == addr0) ? wdata1 : (we0 ? wdata0 : mem_rd(addr0));
            if (we0) begin
                mem[addr0]     <= wdata0;
                written[addr0] <= 1'b1;
            end
        end
        if (ce1) begin
            rdata1 <= (ce0 && we0 && addr0 == addr1) ? wdata0 : (we1 ? wdata1 : mem_rd(addr1));
            if (we1) begin
                mem[addr1]     <= wdata1;
                written[addr1] <= 1'b1;
            end
        end
    end

    // Reference state
    logic [DW-1:0] shadow [AR];
    int unsigned   m_ptr, m_k;
    bit            m_clear, m_done;
    bit            p_vld [N];
    logic [DW-1:0] p_data [N];
    int unsigned   n_checks = 0, n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] a_of(int r);
        return req_addr[r*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] d_of(int r);
        return req_wdata[r*DW +: DW];
    endfunction

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        bit            n_vld [N];
        logic [DW-1:0] n_data [N];
        bit            done_next;
        int            cand[$];
        int            g[$];
        logic [N-1:0]  exp_rdy;
        logic          pce [2];
        logic          pwe [2];
        logic [AW-1:0] pad [2];
        logic [DW-1:0] pwd [2];
        #1;
        pce = '{ce0, ce1};
        pwe = '{we0, we1};
        pad = '{addr0, addr1};
        pwd = '{wdata0, wdata1};
        done_next = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            n_vld[i]  = 1'b0;
            n_data[i] = '0;
        end
        if (!rst_n) begin
            check_eq("ready_in_reset", req_ready, '0);
            check_eq("ce0_in_reset", ce0, 0);
            check_eq("ce1_in_reset", ce1, 0);
            m_ptr   = 0;
            m_k     = 0;
            m_clear = 1'b0;
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                check_eq($sformatf("rsp_valid[%0d]", i), rsp_valid[i], p_vld[i]);
                if (p_vld[i]) check_eq($sformatf("rsp_data[%0d]", i), rsp_data[i*DW +: DW],
                                       p_data[i]);
            end
            check_eq("clr_busy", clr_busy, m_clear);
            check_eq("clr_done", clr_done, m_done);
            if (m_clear) begin
                check_eq("ready_in_clear", req_ready, '0);
                for (int p = 0; p < 2; p++) begin
                    check_eq($sformatf("clr_ce%0d", p), pce[p], 1);
                    check_eq($sformatf("clr_we%0d", p), pwe[p], 1);
                    check_eq($sformatf("clr_addr%0d", p), pad[p], 64'(2 * m_k + p));
                    check_eq($sformatf("clr_wdata%0d", p), pwd[p], 0);
                    shadow[2 * m_k + p] = '0;
                end
                m_k++;
                if (m_k == AR / 2) begin
                    m_clear   = 1'b0;
                    m_k       = 0;
                    done_next = 1'b1;
                end
            end else begin
                for (int j = 0; j < int'(N); j++) begin
                    int r;
                    r = (int'(m_ptr) + j) % int'(N);
                    if (req_valid[r]) cand.push_back(r);
                end
                if (cand.size() > 0) g.push_back(cand[0]);
                if (cand.size() > 1 && !(req_we[cand[0]] && req_we[cand[1]] &&
                                         a_of(cand[0]) == a_of(cand[1])))
                    g.push_back(cand[1]);
                exp_rdy = '0;
                foreach (g[p]) exp_rdy[g[p]] = 1'b1;
                check_eq("req_ready", req_ready, exp_rdy);
                for (int p = 0; p < 2; p++) begin
                    bit gv;
                    gv = (g.size() > p);
                    check_eq($sformatf("ce%0d", p), pce[p], gv);
                    check_eq($sformatf("we%0d", p), pwe[p], gv ? req_we[g[p]] : 1'b0);
                    check_eq($sformatf("addr%0d", p), pad[p], gv ? a_of(g[p]) : '0);
                    check_eq($sformatf("wdata%0d", p), pwd[p], gv ? d_of(g[p]) : '0);
                end
                foreach (g[p]) begin
                    if (!req_we[g[p]]) begin
                        n_vld[g[p]]  = 1'b1;
                        n_data[g[p]] = shadow[a_of(g[p])];
                        foreach (g[q])
                            if (q != p && req_we[g[q]] && a_of(g[q]) == a_of(g[p]))
                                n_data[g[p]] = d_of(g[q]);
                    end
                end
                foreach (g[p]) if (req_we[g[p]]) shadow[a_of(g[p])] = d_of(g[p]);
                if (g.size() > 0) m_ptr = (g[g.size() - 1] + 1) % N;
                if (clr_start) m_clear = 1'b1;
            end
        end
        m_done = rst_n ? done_next : 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            p_vld[i]  = n_vld[i];
            p_data[i] = n_data[i];
        end
        @(negedge clk);
    endtask

    task automatic idle();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        clr_start = 1'b0;
    endtask

    task automatic set_req(input int r, input bit we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_valid[r]         = 1'b1;
        req_we[r]            = we;
        req_addr[r*AW +: AW] = a;
        req_wdata[r*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    int unsigned busy_cnt;

    initial begin
        for (int i = 0; i < int'(AR); i++) shadow[i] = init_val(i);
        for (int i = 0; i < int'(N); i++) p_vld[i] = 1'b0;
        m_done = 1'b0;
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        do_reset();
        step();

        // Single read of preloaded word
        set_req(2, 1'b0, 12'h010, '0);
        #1 check_eq("single_ready", req_ready, 4'b0100);
        step();
        idle();
        #1 check_eq("single_rsp", rsp_data[2*DW +: DW], 64'hA5);
        step();

        // Round robin from pointer 0 with all four reading
        do_reset();
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < int'(N); r++) set_req(r, 1'b0, AW'(r + 8), '0);
            #1 check_eq($sformatf("rr_cycle%0d", c), req_ready, (c == 1) ? 4'b1100 : 4'b0011);
            step();
        end
        idle();
        step();

        // Write-write conflict on 0x100
        set_req(0, 1'b1, 12'h100, 64'h11);
        set_req(1, 1'b1, 12'h100, 64'h22);
        #1 check_eq("ww_c1_ce1", ce1, 0);
        step();
        req_valid[0] = 1'b0;
        #1 check_eq("ww_c2_ready", req_ready, 4'b0010);
        step();
        idle();
        set_req(3, 1'b0, 12'h100, '0);
        step();
        idle();
        #1 check_eq("ww_final", rsp_data[3*DW +: DW], 64'h22);
        step();

        // Same-cycle write and read of 0x040
        set_req(0, 1'b1, 12'h040, 64'h55);
        set_req(1, 1'b0, 12'h040, '0);
        step();
        idle();
        #1 check_eq("rw_forward", rsp_data[1*DW +: DW], 64'h55);
        step();

        // Full clear with all requesters pending
        for (int r = 0; r < int'(N); r++) set_req(r, 1'b0, AW'(r), '0);
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < int'(AR / 2) + 4 && (c == 0 || clr_busy); c++) begin
            #1 if (clr_busy) busy_cnt++;
            step();
        end
        check_eq("clr_busy_cycles", busy_cnt, AR / 2);
        idle();
        set_req(2, 1'b0, 12'hFFF, '0);
        step();
        idle();
        #1 check_eq("after_clear_fff", rsp_data[2*DW +: DW], 0);
        step();

        // Reset aborts a clear at cycle 100
        idle();
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        repeat (100) step();
        do_reset();
        set_req(1, 1'b0, 12'h300, '0);
        set_req(2, 1'b0, 12'h301, '0);
        #1 check_eq("post_abort_ready", req_ready, 4'b0110);
        step();
        idle();
        step();

        // Randomized traffic over a small address window to provoke conflicts
        for (int c = 0; c < 600; c++) begin
            idle();
            for (int r = 0; r < int'(N); r++)
                if ($urandom_range(0, 3) != 0)
                    set_req(r, 1'($urandom), AW'($urandom_range(0, 5)),
                            {$urandom, $urandom});
            step();
        end
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
